// File: rtl/clkseq_pkg.sv
// Shared types and helpers for the ADC clock-source changeover sequencer.
package clkseq_pkg;

    typedef enum logic [2:0] {
        ST_INT       = 3'd0,
        ST_RST       = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_PHASE     = 3'd3,
        ST_EXT       = 3'd4,
        ST_FAIL      = 3'd5
    } state_e;

    localparam int PHASE_W = 9;

    function automatic int clog2(input int unsigned value);
        int unsigned v;
        clog2 = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v != 0) begin
            clog2 = clog2 + 1;
            v = v >> 1;
        end
    endfunction

endpackage

// File: rtl/clkmgr_sequencer_if.sv
// Host-side request/status bundle of the clock changeover sequencer.
interface clkmgr_sequencer_if;
    import clkseq_pkg::*;

    logic               sel_ext;
    logic               resync;
    logic               phase_update;
    logic [PHASE_W-1:0] phase_cfg;
    logic               dcm_locked;
    logic               phase_done;
    logic               use_ext_clk;
    logic               dcm_rst;
    logic               phase_load;
    logic [PHASE_W-1:0] phase_value;
    logic               ready;
    logic               fail;
    logic [2:0]         state;
    logic [1:0]         retry_cnt;

    modport master (
        output sel_ext, resync, phase_update, phase_cfg, dcm_locked, phase_done,
        input  use_ext_clk, dcm_rst, phase_load, phase_value, ready, fail, state, retry_cnt
    );

    modport slave (
        input  sel_ext, resync, phase_update, phase_cfg, dcm_locked, phase_done,
        output use_ext_clk, dcm_rst, phase_load, phase_value, ready, fail, state, retry_cnt
    );

endinterface

// File: rtl/clkseq_sync2.sv
// Generic two-flop synchronizer with synchronous reset; two-cycle latency.
module clkseq_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: non-blocking assignments so sync_q takes the old meta_q, giving a true two-stage pipe.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/clkmgr_sequencer.sv
// DCM reset / lock / phase-restore sequencer driving the ADC BUFGMUX select.
// Define CLKSEQ_AUTO_RETRY_EN to retry re-lock up to MAX_RETRY times before failing.
module clkmgr_sequencer
    import clkseq_pkg::*;
#(
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int MAX_RETRY    = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               sel_ext_i,
    input  logic               resync_i,
    input  logic               phase_update_i,
    input  logic [PHASE_W-1:0] phase_cfg_i,
    input  logic               dcm_locked_i,
    input  logic               phase_done_i,
    output logic               use_ext_clk_o,
    output logic               dcm_rst_o,
    output logic               phase_load_o,
    output logic [PHASE_W-1:0] phase_value_o,
    output logic               ready_o,
    output logic               fail_o,
    output logic [2:0]         state_o,
    output logic [1:0]         retry_cnt_o
);

`ifdef CLKSEQ_AUTO_RETRY_EN
    localparam bit AUTO_RETRY = 1'b1;
`else
    localparam bit AUTO_RETRY = 1'b0;
`endif

    localparam int CNT_W = clog2(((RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE) + 1);
    localparam int TMO_W = clog2(LOCK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX     = TMO_W'(LOCK_TIMEOUT);
    localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRY);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [1:0]         retry_q, retry_d;
    logic               from_ext_q, from_ext_d;
    logic               use_ext_q, use_ext_d;
    logic               dcm_rst_q, dcm_rst_d;
    logic               phase_load_q, phase_load_d;
    logic [PHASE_W-1:0] phase_value_q, phase_value_d;
    logic               ready_q, ready_d;
    logic               fail_q, fail_d;
    logic               lk;
    logic               fault;
    logic               entering;

    clkseq_sync2 #(.WIDTH(1)) u_lock_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (dcm_locked_i),
        .q_o     (lk)
    );

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        from_ext_d = from_ext_q;
        fault      = 1'b0;

        unique case (state_q)
            ST_INT: begin
                if (sel_ext_i) begin
                    state_d = ST_RST;
                    retry_d = '0;
                end
            end
            ST_RST: begin
                if (!sel_ext_i)            state_d = ST_INT;
                else if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (!sel_ext_i)                      state_d = ST_INT;
                else if (tmo_q == TMO_LAST)          fault   = 1'b1;
                else if (lk && cnt_q == STABLE_LAST) state_d = ST_PHASE;
            end
            ST_PHASE: begin
                // cnt_q != 0 skips the load cycle before trusting phase_done_i.
                if (!sel_ext_i)                          state_d = ST_INT;
                else if (!lk || tmo_q == TMO_LAST)       fault   = 1'b1;
                else if (cnt_q != '0 && phase_done_i)    state_d = ST_EXT;
            end
            ST_EXT: begin
                if (!sel_ext_i)          state_d = ST_INT;
                else if (!lk)            fault   = 1'b1;
                else if (resync_i)       state_d = ST_RST;
                else if (phase_update_i) state_d = ST_PHASE;
            end
            ST_FAIL: begin
                if (!sel_ext_i) state_d = ST_INT;
                else if (resync_i) begin
                    state_d = ST_RST;
                    retry_d = '0;
                end
            end
            default: state_d = ST_INT;
        endcase

        if (fault) begin
            if (AUTO_RETRY && retry_q < RETRY_MAX) begin
                state_d = ST_RST;
                retry_d = retry_q + 1'b1;
            end else begin
                state_d = ST_FAIL;
            end
        end

        entering = (state_d != state_q);
        if (entering && state_d == ST_PHASE) from_ext_d = (state_q == ST_EXT);

        cnt_d = '0;
        tmo_d = '0;
        if (!entering) begin
            tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
            unique case (state_q)
                ST_RST:       cnt_d = cnt_q + 1'b1;
                ST_WAIT_LOCK: cnt_d = lk ? cnt_q + 1'b1 : '0;
                ST_PHASE:     cnt_d = (cnt_q == '0) ? CNT_W'(1) : cnt_q;
                default:      cnt_d = '0;
            endcase
        end

        // Outputs are registered from the next state so they switch with the state itself.
        phase_load_d  = entering && (state_d == ST_PHASE);
        phase_value_d = phase_load_d ? phase_cfg_i : phase_value_q;
        use_ext_d     = (state_d == ST_EXT) || (state_d == ST_PHASE && from_ext_d);
        dcm_rst_d     = (state_d == ST_RST);
        ready_d       = (state_d == ST_INT) || (state_d == ST_EXT);
        fail_d        = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_INT;
            cnt_q         <= '0;
            tmo_q         <= '0;
            retry_q       <= '0;
            from_ext_q    <= 1'b0;
            use_ext_q     <= 1'b0;
            dcm_rst_q     <= 1'b0;
            phase_load_q  <= 1'b0;
            phase_value_q <= '0;
            ready_q       <= 1'b1;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tmo_q         <= tmo_d;
            retry_q       <= retry_d;
            from_ext_q    <= from_ext_d;
            use_ext_q     <= use_ext_d;
            dcm_rst_q     <= dcm_rst_d;
            phase_load_q  <= phase_load_d;
            phase_value_q <= phase_value_d;
            ready_q       <= ready_d;
            fail_q        <= fail_d;
        end
    end

    assign use_ext_clk_o = use_ext_q;
    assign dcm_rst_o     = dcm_rst_q;
    assign phase_load_o  = phase_load_q;
    assign phase_value_o = phase_value_q;
    assign ready_o       = ready_q;
    assign fail_o        = fail_q;
    assign state_o       = state_q;
    assign retry_cnt_o   = retry_q;

endmodule

// File: tb/tb_clkmgr_sequencer.sv
// Directed bench for clkmgr_sequencer; expectations hold with or without CLKSEQ_AUTO_RETRY_EN.
module tb_clkmgr_sequencer;
    import clkseq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    clkmgr_sequencer_if bus ();

    always #5 clk = ~clk;

    clkmgr_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_STABLE  (8),
        .LOCK_TIMEOUT (64),
        .MAX_RETRY    (2)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .sel_ext_i      (bus.sel_ext),
        .resync_i       (bus.resync),
        .phase_update_i (bus.phase_update),
        .phase_cfg_i    (bus.phase_cfg),
        .dcm_locked_i   (bus.dcm_locked),
        .phase_done_i   (bus.phase_done),
        .use_ext_clk_o  (bus.use_ext_clk),
        .dcm_rst_o      (bus.dcm_rst),
        .phase_load_o   (bus.phase_load),
        .phase_value_o  (bus.phase_value),
        .ready_o        (bus.ready),
        .fail_o         (bus.fail),
        .state_o        (bus.state),
        .retry_cnt_o    (bus.retry_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits on negedges until state_o matches; an expired budget shows up as a failed check.
    task automatic wait_state(input string tag, input logic [2:0] target, input int budget,
                              output int n);
        n = 0;
        while (bus.state !== target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.state), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(bus.state), 32'd0);
        check({tag, "_use_ext"}, 32'(bus.use_ext_clk), 32'd0);
        check({tag, "_dcm_rst"}, 32'(bus.dcm_rst), 32'd0);
        check({tag, "_load"}, 32'(bus.phase_load), 32'd0);
        check({tag, "_value"}, 32'(bus.phase_value), 32'd0);
        check({tag, "_ready"}, 32'(bus.ready), 32'd1);
        check({tag, "_fail"}, 32'(bus.fail), 32'd0);
        check({tag, "_retry"}, 32'(bus.retry_cnt), 32'd0);
    endtask

    initial begin
        int n;
        int k;
        int rst_hi;
        int loads;
        int lock_wait;
        logic prev_rst;
        logic [8:0] load_val;
        logic pattern [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

        reset            = 1'b1;
        bus.sel_ext      = 1'b0;
        bus.resync       = 1'b0;
        bus.phase_update = 1'b0;
        bus.phase_cfg    = '0;
        bus.dcm_locked   = 1'b0;
        bus.phase_done   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // 1: full changeover, lock raised five cycles after DCM reset drops.
        bus.phase_cfg  = 9'h05A;
        bus.phase_done = 1'b1;
        bus.sel_ext    = 1'b1;
        rst_hi = 0; loads = 0; load_val = '0; prev_rst = 1'b0; lock_wait = -1; k = 0;
        while (bus.use_ext_clk !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
            if (bus.dcm_rst) rst_hi++;
            if (bus.phase_load) begin
                loads++;
                load_val = bus.phase_value;
            end
            if (prev_rst && !bus.dcm_rst) lock_wait = 5;
            if (lock_wait > 0) lock_wait--;
            if (lock_wait == 0) bus.dcm_locked = 1'b1;
            prev_rst = bus.dcm_rst;
        end
        check("t1_use_ext", 32'(bus.use_ext_clk), 32'd1);
        check("t1_rst_cycles", 32'(rst_hi), 32'd4);
        check("t1_loads", 32'(loads), 32'd1);
        check("t1_load_val", 32'(load_val), 32'h05A);
        check("t1_state", 32'(bus.state), 32'd4);
        check("t1_ready", 32'(bus.ready), 32'd1);

        // Phase update while external: select stays, ready drops, new value loaded.
        bus.phase_cfg    = 9'h0F0;
        bus.phase_update = 1'b1;
        @(negedge clk);
        bus.phase_update = 1'b0;
        check("upd_state", 32'(bus.state), 32'd3);
        check("upd_use_ext", 32'(bus.use_ext_clk), 32'd1);
        check("upd_ready", 32'(bus.ready), 32'd0);
        check("upd_load", 32'(bus.phase_load), 32'd1);
        check("upd_val", 32'(bus.phase_value), 32'h0F0);
        repeat (2) @(negedge clk);
        check("upd_back_ext", 32'(bus.state), 32'd4);

        bus.sel_ext    = 1'b0;
        bus.dcm_locked = 1'b0;
        @(negedge clk);
        check("ext_to_int", 32'(bus.state), 32'd0);
        check("ext_to_int_use", 32'(bus.use_ext_clk), 32'd0);

        // 2: glitchy lock restarts the stable count; 2 sync + 8 stable + 2 phase edges.
        bus.sel_ext = 1'b1;
        wait_state("t2_wait_lock", 3'd2, 20, n);
        foreach (pattern[i]) begin
            bus.dcm_locked = pattern[i];
            @(negedge clk);
        end
        bus.dcm_locked = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.use_ext_clk !== 1'b1 && k < 40);
        check("t2_relock_edges", 32'(k), 32'd12);

        // 4: lock loss in external mode.
        bus.dcm_locked = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.use_ext_clk !== 1'b0 && k < 10);
        check("t4_loss_edges", 32'(k), 32'd3);
`ifdef CLKSEQ_AUTO_RETRY_EN
        check("t4_retry_state", 32'(bus.state), 32'd1);
        bus.dcm_locked = 1'b1;
        wait_state("t4_relock", 3'd4, 100, n);
        check("t4_retry_cnt", 32'(bus.retry_cnt), 32'd1);
        check("t4_use_ext", 32'(bus.use_ext_clk), 32'd1);
`else
        check("t4_fail_state", 32'(bus.state), 32'd5);
        check("t4_fail_flag", 32'(bus.fail), 32'd1);
`endif
        bus.sel_ext    = 1'b0;
        bus.dcm_locked = 1'b0;
        @(negedge clk);
        check("t4_int", 32'(bus.state), 32'd0);

        // 3: lock never asserts.
        bus.sel_ext = 1'b1;
        wait_state("t3_wait_lock", 3'd2, 20, n);
        wait_state("t3_fail", 3'd5, 400, n);
`ifdef CLKSEQ_AUTO_RETRY_EN
        check("t3_fail_edges", 32'(n), 32'd200);
        check("t3_retry_cnt", 32'(bus.retry_cnt), 32'd2);
`else
        check("t3_fail_edges", 32'(n), 32'd64);
        check("t3_retry_cnt", 32'(bus.retry_cnt), 32'd0);
`endif
        check("t3_fail_flag", 32'(bus.fail), 32'd1);
        check("t3_use_ext", 32'(bus.use_ext_clk), 32'd0);
        check("t3_ready", 32'(bus.ready), 32'd0);

        bus.resync = 1'b1;
        @(negedge clk);
        bus.resync = 1'b0;
        check("resync_state", 32'(bus.state), 32'd1);
        check("resync_retry", 32'(bus.retry_cnt), 32'd0);
        check("resync_fail", 32'(bus.fail), 32'd0);
        bus.sel_ext = 1'b0;
        @(negedge clk);
        check("abort_rst_state", 32'(bus.state), 32'd0);
        check("abort_rst_dcm", 32'(bus.dcm_rst), 32'd0);

        // 5: abort during WAIT_LOCK, then abort on the very cycle of the timeout.
        bus.sel_ext = 1'b1;
        wait_state("t5_wait_lock", 3'd2, 20, n);
        repeat (3) @(negedge clk);
        bus.sel_ext = 1'b0;
        @(negedge clk);
        check("t5_abort_state", 32'(bus.state), 32'd0);
        check("t5_abort_dcm", 32'(bus.dcm_rst), 32'd0);
        check("t5_abort_ready", 32'(bus.ready), 32'd1);

        bus.sel_ext = 1'b1;
        wait_state("t5b_wait_lock", 3'd2, 20, n);
        repeat (63) @(negedge clk);
        check("t5b_pre_timeout", 32'(bus.state), 32'd2);
        bus.sel_ext = 1'b0;
        @(negedge clk);
        check("t5b_int_wins", 32'(bus.state), 32'd0);
        check("t5b_no_fail", 32'(bus.fail), 32'd0);

        // 6: reset while PHASE waits for phase_done.
        bus.phase_cfg  = 9'h1C3;
        bus.phase_done = 1'b0;
        bus.dcm_locked = 1'b1;
        bus.sel_ext    = 1'b1;
        wait_state("t6_phase", 3'd3, 40, n);
        check("t6_load", 32'(bus.phase_load), 32'd1);
        check("t6_val", 32'(bus.phase_value), 32'h1C3);
        check("t6_use_ext", 32'(bus.use_ext_clk), 32'd0);
        @(negedge clk);
        check("t6_load_once", 32'(bus.phase_load), 32'd0);
        check("t6_still_phase", 32'(bus.state), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6_reset");
        reset       = 1'b0;
        bus.sel_ext = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
